// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package serial_adder_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_DONE  = DONE
   } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
   half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

   assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two bits.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: loads operands in parallel, adds LSB-first over WIDTH
// cycles through one full-adder cell, returns sum/cout with a done pulse.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       dbg_state
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   // Handshake: start is sampled on each rising edge; it is accepted only in
   // IDLE or DONE, ignored in SHIFT. done is high for exactly the one cycle
   // after the final bit, when sum/cout first show the new result.

   state_e           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] sbit_msb;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             fa_s;
   logic             fa_cout;

   full_adder_cell u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // Sum bit enters the working result from the MSB side; written this way
   // so it also holds for WIDTH=1.
   always_comb begin
      sbit_msb            = '0;
      sbit_msb[WIDTH-1]   = fa_s;
      res_d               = (res_q >> 1) | sbit_msb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  carry_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               a_sr_q  <= a_sr_q >> 1;
               b_sr_q  <= b_sr_q >> 1;
               res_q   <= res_d;
               carry_q <= fa_cout;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  sum_q   <= res_d;
                  cout_q  <= fa_cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign dbg_state = state_q;

endmodule
